// File: rtl/keypad_emulator.sv
// ----------------------------------------------------------------------------
// keypad_emulator
//
// Purpose:
//   Emulates a 3-column x 4-row telephone keypad as seen by a column-scanning
//   keypad controller. Key codes are queued in a 4-entry FIFO. Each code is
//   "pressed" for HOLD_CYC cycles and then "released" for GAP_CYC cycles.
//   While a key is pressed, the row line of that key is driven whenever the
//   scanner drives the key's column.
//
// Parameters:
//   HOLD_CYC    - clk cycles a key is held pressed (1..131071)
//   GAP_CYC     - clk cycles of release after each press (1..131071)
//
// Ports:
//   clk         - system clock (25 MHz)
//   rst         - asynchronous, active-high reset
//   key_col     - column drive from the scanner (col1=001, col2=010, col3=100)
//   key_row     - registered row sense returned to the scanner
//   key_code    - code to enqueue: 0-9 digits, 10 '*', 11 '#'
//   key_valid   - enqueue request, accepted when key_ready is high
//   key_ready   - FIFO can accept a code
//   busy        - press/gap in progress or FIFO non-empty
//   active_code - code currently (or most recently) pressed
//   press_done  - one-cycle pulse at the end of each gap
//   err         - one-cycle pulse after an invalid code (12-15) is accepted
//   fifo_cnt    - number of queued codes (0-4)
//
// Configuration:
//   KEYPAD_EMU_BOUNCE_EN - when defined, the emulated contact bounces
//   (closed/open, 16 cycles each) during the first 128 cycles of a press and
//   then stays closed. When undefined, the contact is closed for the whole
//   press.
// ----------------------------------------------------------------------------
module keypad_emulator #(
    parameter int HOLD_CYC = 100000,
    parameter int GAP_CYC  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_col,
    output logic [3:0] key_row,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic [3:0] active_code,
    output logic       press_done,
    output logic       err,
    output logic [2:0] fifo_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [16:0] HOLD_LD = 17'(HOLD_CYC);
    localparam logic [16:0] GAP_LD  = 17'(GAP_CYC);

    localparam logic [2:0] FIFO_FULL  = 3'd4;
    localparam logic [3:0] CODE_MAX   = 4'd11;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]  r_fifo [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_fifo_cnt;
    logic [1:0]  r_state;
    logic [16:0] r_cnt;
    logic [3:0]  r_active_code;
    logic [3:0]  r_key_row;
    logic        r_press_done;
    logic        r_err;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_code_ok;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_col_sel;
    logic [3:0]  w_row_hot;
    logic        w_col_hit;
    logic        w_contact;
    logic        w_cnt_last;
    logic [3:0]  w_row_next;

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    // Ready depends only on the registered count, so there is no
    // combinational path from key_valid to key_ready.
    assign key_ready = (r_fifo_cnt != FIFO_FULL);
    assign w_accept  = key_valid && key_ready;
    assign w_code_ok = (key_code <= CODE_MAX);
    assign w_push    = w_accept && w_code_ok;
    assign w_pop     = (r_state == ST_IDLE) && (r_fifo_cnt != 3'd0);

    // NOTE: the FIFO storage has no reset; entries are only read when
    // r_fifo_cnt says they were written, and leaving them unreset lets
    // the array map onto plain flops or distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= key_code;
        end
    end

    // NOTE: all state updates in clocked blocks are non-blocking so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_fifo_cnt <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            // An invalid code is consumed by the handshake but never stored.
            r_err <= w_accept && !w_code_ok;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end

            // Simultaneous push and pop leave the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 3'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 3'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Press / gap sequencer
    // ------------------------------------------------------------------
    // Counters load the parameter value and count down to 1; treating 0
    // as terminal too keeps a zero parameter from wrapping to 2^17 cycles.
    assign w_cnt_last = (r_cnt <= 17'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 17'd0;
            r_active_code <= 4'd0;
            r_press_done  <= 1'b0;
        end else begin
            r_press_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_active_code <= r_fifo[r_rd_ptr];
                        r_cnt         <= HOLD_LD;
                        r_state       <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (w_cnt_last) begin
                        r_cnt   <= GAP_LD;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 17'd1;
                    end
                end
                ST_GAP: begin
                    if (w_cnt_last) begin
                        r_cnt        <= 17'd0;
                        r_state      <= ST_IDLE;
                        r_press_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 17'd1;
                    end
                end
                default: begin
                    r_cnt   <= 17'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key matrix mapping
    //   col1 (bit0): 1 4 7 *   col2 (bit1): 2 5 8 0   col3 (bit2): 3 6 9 #
    //   rows top to bottom: 0001 0010 0100 1000
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no code
    // value can leave a path unassigned and infer a latch.
    always_comb begin
        w_col_sel = 3'b000;
        w_row_hot = 4'b0000;
        case (r_active_code)
            4'd1:  begin w_col_sel = 3'b001; w_row_hot = 4'b0001; end
            4'd2:  begin w_col_sel = 3'b010; w_row_hot = 4'b0001; end
            4'd3:  begin w_col_sel = 3'b100; w_row_hot = 4'b0001; end
            4'd4:  begin w_col_sel = 3'b001; w_row_hot = 4'b0010; end
            4'd5:  begin w_col_sel = 3'b010; w_row_hot = 4'b0010; end
            4'd6:  begin w_col_sel = 3'b100; w_row_hot = 4'b0010; end
            4'd7:  begin w_col_sel = 3'b001; w_row_hot = 4'b0100; end
            4'd8:  begin w_col_sel = 3'b010; w_row_hot = 4'b0100; end
            4'd9:  begin w_col_sel = 3'b100; w_row_hot = 4'b0100; end
            4'd10: begin w_col_sel = 3'b001; w_row_hot = 4'b1000; end
            4'd0:  begin w_col_sel = 3'b010; w_row_hot = 4'b1000; end
            4'd11: begin w_col_sel = 3'b100; w_row_hot = 4'b1000; end
            default: begin
                w_col_sel = 3'b000;
                w_row_hot = 4'b0000;
            end
        endcase
    end

    // Only the key's own column bit matters; other driven columns are
    // ignored, and an undriven column bus never closes the contact.
    assign w_col_hit = |(key_col & w_col_sel);

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Cycles elapsed since the press began (0 on the first PRESS cycle).
    logic [16:0] w_elapsed;
    assign w_elapsed = HOLD_LD - r_cnt;
    // Closed for 16, open for 16, ... over the first 128 cycles, then closed.
    assign w_contact = (w_elapsed >= 17'd128) || !w_elapsed[4];
`else
    assign w_contact = 1'b1;
`endif

    assign w_row_next = ((r_state == ST_PRESS) && w_contact && w_col_hit)
                        ? w_row_hot : 4'b0000;

    // Row sense is registered, one clk behind key_col; the asynchronous
    // reset releases it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_row <= 4'b0000;
        end else begin
            r_key_row <= w_row_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign key_row     = r_key_row;
    assign busy        = (r_state != ST_IDLE) || (r_fifo_cnt != 3'd0);
    assign active_code = r_active_code;
    assign press_done  = r_press_done;
    assign err         = r_err;
    assign fifo_cnt    = r_fifo_cnt;

endmodule
